bsg_link_ddr_downstream_rx: RTL

//  Receive end of the BSG DDR link, single io clock domain. Collects 16-bit

---
 rtl/bsg_link_ddr_downstream_rx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/bsg_link_ddr_downstream_rx.sv
// bsg_link_ddr_downstream_rx
//   Receive end of the BSG DDR link in a single io clock domain. Assembles
//   four 16-bit link beats into a 64-bit word, buffers completed words in a
//   small FIFO presented to the core with valid/yumi, and returns one credit
//   token upstream per 2**LG_TOKEN_DECIM words consumed.
//   Optional feature macro: BSG_LINK_RX_ERR_STATUS_EN (sticky overflow and
//   misalign status on err_o / err_code_o; tied to 0 when undefined).
//
//   Handshake: core_valid_o is high whenever the FIFO holds a word, and
//   core_data_o is then the head word. core_yumi_i pops the head in the same
//   cycle and is only meaningful while core_valid_o is high; a yumi with
//   core_valid_o low is ignored. The head is stable until it is yumied.
module bsg_link_ddr_downstream_rx #(
    parameter int FIFO_ELS       = 8,
    parameter int LG_TOKEN_DECIM = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  io_valid_i,
    input  logic [15:0] io_data_i,
    output logic        core_valid_o,
    output logic [63:0] core_data_o,
    input  logic        core_yumi_i,
    output logic        token_o,
    output logic        token_clk_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

    localparam int IDX_W = $clog2(FIFO_ELS);
    localparam int PTR_W = IDX_W + 1;

    // Beat assembly state: beats 0..2 are held in part_q until beat 3 arrives.
    logic [1:0]                bc_q, bc_d;
    logic [47:0]               part_q, part_d;
    logic                      push_req;
    logic                      misalign;
    logic [63:0]               push_word;

    // FIFO storage and pointers (one extra pointer bit separates full/empty).
    logic [63:0]               mem_q [FIFO_ELS];
    logic [63:0]               mem_d [FIFO_ELS];
    logic [PTR_W-1:0]          wptr_q, wptr_d;
    logic [PTR_W-1:0]          rptr_q, rptr_d;
    logic                      empty;
    logic                      full;
    logic                      pop;
    logic                      push;

    // Credit return.
    logic [LG_TOKEN_DECIM-1:0] tok_cnt_q, tok_cnt_d;
    logic                      token_q, token_d;
    logic                      token_clk_q, token_clk_d;

    // A beat with only one channel valid means the two channels lost lockstep.
    assign misalign  = io_valid_i[0] ^ io_valid_i[1];
    assign push_word = {io_data_i, part_q};

    // Beat assembly: place accepted beats, complete on beat 3, restart on misalign.
    always_comb begin
        bc_d     = bc_q;
        part_d   = part_q;
        push_req = 1'b0;
        if (misalign) begin
            bc_d   = 2'd0;
            part_d = '0;
        end else if (io_valid_i == 2'b11) begin
            case (bc_q)
                2'd0: part_d[15:0]  = io_data_i;
                2'd1: part_d[31:16] = io_data_i;
                2'd2: part_d[47:32] = io_data_i;
                default: begin
                    push_req = 1'b1;
                    part_d   = '0;
                end
            endcase
            bc_d = bc_q + 2'd1;
        end
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                   (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);
    assign pop   = core_yumi_i && !empty;
    // When full, a same-cycle pop frees the slot the new word lands in.
    assign push  = push_req && (!full || pop);

    // FIFO next state: write completed word at the tail, advance pointers.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wptr_q[IDX_W-1:0]] = push_word;
        end
        wptr_d = wptr_q + PTR_W'(push);
        rptr_d = rptr_q + PTR_W'(pop);
    end

    // Token next state: pulse and toggle when the pop counter wraps.
    always_comb begin
        tok_cnt_d   = tok_cnt_q + LG_TOKEN_DECIM'(pop);
        token_d     = pop && (&tok_cnt_q);
        token_clk_d = token_clk_q ^ token_d;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bc_q        <= 2'd0;
            part_q      <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            tok_cnt_q   <= '0;
            token_q     <= 1'b0;
            token_clk_q <= 1'b0;
        end else begin
            bc_q        <= bc_d;
            part_q      <= part_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            tok_cnt_q   <= tok_cnt_d;
            token_q     <= token_d;
            token_clk_q <= token_clk_d;
        end
    end

    // FIFO storage needs no reset; the head is masked while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign core_valid_o = !empty;
    assign core_data_o  = empty ? 64'd0 : mem_q[rptr_q[IDX_W-1:0]];
    assign token_o      = token_q;
    assign token_clk_o  = token_clk_q;

`ifdef BSG_LINK_RX_ERR_STATUS_EN
    logic [1:0] err_code_q, err_code_d;

    // Sticky status: bit0 a completed word was dropped, bit1 a misaligned beat.
    always_comb begin
        err_code_d = err_code_q | {misalign, push_req && !push};
    end

    // Status register; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_code_q <= 2'b00;
        end else begin
            err_code_q <= err_code_d;
        end
    end

    assign err_code_o = err_code_q;
    assign err_o      = |err_code_q;
`else
    assign err_code_o = 2'b00;
    assign err_o      = 1'b0;
`endif

endmodule
